// File: rtl/q_updater_pkg.sv
`default_nettype none
// ============================================================================
// Module      : q_pkg
// Description : Shared Q-table definitions used by the Q-table updater and the
//               action selector: value/row/accumulator widths, the action to
//               lane mapping, and the updater FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package q_pkg;

  localparam int Q_W   = 16;          // one unsigned Q value
  localparam int ROW_W = 64;          // one Q-table row (4 actions)
  localparam int ACC_W = 19;          // signed TD arithmetic width

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_NXT = 3'd1,
    RD_CUR = 3'd2,
    CAP    = 3'd3,
    CALC   = 3'd4,
    WR     = 3'd5
  } q_state_e;

  // Action 3 lives in the low lane, action 0 in the high lane, so the bit
  // offset is (3 - action) * 16, which for a 2-bit action is ~action * 16.
  function automatic logic [5:0] lane_lsb(input logic [1:0] act);
    return {~act, 4'b0000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_updater_row_max.sv
`default_nettype none
// ============================================================================
// Module      : row_max
// Description : Combinational unsigned maximum over the four Q lanes of a row.
// Ports       : row     - 64-bit Q-table row
//               max_val - largest of the four 16-bit lanes
// Revision    : 1.0 - initial release
// ============================================================================
module row_max
  import q_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  output logic [Q_W-1:0]   max_val
);

  logic [Q_W-1:0] w_max_hi;
  logic [Q_W-1:0] w_max_lo;

  // Two-level compare tree
  assign w_max_hi = (row[63:48] > row[47:32]) ? row[63:48] : row[47:32];
  assign w_max_lo = (row[31:16] > row[15:0])  ? row[31:16] : row[15:0];
  assign max_val  = (w_max_hi > w_max_lo) ? w_max_hi : w_max_lo;

endmodule
`default_nettype wire

// File: rtl/q_updater.sv
`default_nettype none
// ============================================================================
// Module      : q_updater
// Description : Q-learning table write-back. Reads max Q of s' (skipped when
//               terminal) and the row of s, computes the TD update with
//               shift-based alpha/gamma, saturates to 16 bits unsigned and
//               writes the row back through a single-port synchronous memory.
// Ports       : clk, rst              - clock, async active-high reset
//               start                 - update request (IDLE only)
//               state/action/
//               next_state/reward/
//               terminal              - transition to learn from
//               busy, upd_done, q_new - status and last written value
//               mem_*                 - Q-table memory port (1-cycle read)
// Revision    : 1.0 - initial release
// ============================================================================
module q_updater
  import q_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state,
  input  logic [3:0]         action,
  input  logic [STATE_W-1:0] next_state,
  input  logic [15:0]        reward,
  input  logic               terminal,
  output logic               busy,
  output logic               upd_done,
  output logic [Q_W-1:0]     q_new,
  output logic [STATE_W-1:0] mem_addr,
  output logic               mem_rd_en,
  input  logic [ROW_W-1:0]   mem_rdata,
  output logic               mem_wr_en,
  output logic [ROW_W-1:0]   mem_wdata
);

  q_state_e r_fsm, w_fsm_nxt;

  logic [STATE_W-1:0] r_state;
  logic [1:0]         r_act;
  logic [15:0]        r_reward;
  logic               r_terminal;
  logic [Q_W-1:0]     r_max_next;
  logic [Q_W-1:0]     r_q_sa;
  logic [ROW_W-1:0]   r_row;

  logic               r_busy, r_upd_done, r_mem_rd_en, r_mem_wr_en;
  logic [Q_W-1:0]     r_q_new;
  logic [STATE_W-1:0] r_mem_addr;
  logic [ROW_W-1:0]   r_mem_wdata;

  logic               w_accept;
  logic [STATE_W-1:0] w_cur_addr;
  logic [5:0]         w_lane;
  logic [Q_W-1:0]     w_row_max;
  logic [ROW_W-1:0]   w_wdata;
  logic [Q_W-1:0]     w_q_new;
  logic signed [ACC_W-1:0] w_max_ext, w_qsa_ext, w_rew_ext;
  logic signed [ACC_W-1:0] w_disc, w_target, w_delta, w_upd;

  // Only the low two action bits select a lane
  logic w_unused;
  assign w_unused = &{1'b0, action[3:2]};

  assign w_accept = (r_fsm == IDLE) && start;
  // In IDLE the latch has not happened yet, so the live input is used
  assign w_cur_addr = (r_fsm == IDLE) ? state : r_state;
  // r_act is stable from acceptance onward, and CAP/CALC are both after it
  assign w_lane = lane_lsb(r_act);

  row_max u_row_max (
    .row     (mem_rdata),
    .max_val (w_row_max)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (start) w_fsm_nxt = terminal ? RD_CUR : RD_NXT;
      RD_NXT:  w_fsm_nxt = RD_CUR;
      RD_CUR:  w_fsm_nxt = CAP;
      CAP:     w_fsm_nxt = CALC;
      CALC:    w_fsm_nxt = WR;
      WR:      w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // TD arithmetic (19-bit signed, all operands non-negative except reward)
  // --------------------------------------------------------------------------
  always_comb begin
    w_max_ext = $signed({{(ACC_W-Q_W){1'b0}}, r_max_next});
    w_qsa_ext = $signed({{(ACC_W-Q_W){1'b0}}, r_q_sa});
    w_rew_ext = $signed({{(ACC_W-16){r_reward[15]}}, r_reward});
    w_disc    = r_terminal ? '0 : (w_max_ext - (w_max_ext >>> GAMMA_SHIFT));
    w_target  = w_rew_ext + w_disc;
    w_delta   = w_target - w_qsa_ext;
    w_upd     = w_qsa_ext + (w_delta >>> ALPHA_SHIFT);
    if (w_upd[ACC_W-1])
      w_q_new = '0;
    else if (|w_upd[ACC_W-2:Q_W])
      w_q_new = '1;
    else
      w_q_new = w_upd[Q_W-1:0];
  end

  always_comb begin
    w_wdata = r_row;
    w_wdata[w_lane +: Q_W] = w_q_new;
  end

  // --------------------------------------------------------------------------
  // Datapath and registered outputs; outputs are decoded from the next state
  // so they line up with the state they belong to.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= '0;
      r_act       <= '0;
      r_reward    <= '0;
      r_terminal  <= 1'b0;
      r_max_next  <= '0;
      r_q_sa      <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_upd_done  <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_q_new     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_state    <= state;
        r_act      <= action[1:0];
        r_reward   <= reward;
        r_terminal <= terminal;
      end

      r_busy      <= (w_fsm_nxt != IDLE);
      r_upd_done  <= (w_fsm_nxt == WR);
      r_mem_rd_en <= (w_fsm_nxt == RD_NXT) || (w_fsm_nxt == RD_CUR);
      r_mem_wr_en <= (w_fsm_nxt == WR);

      // RD_NXT is only ever entered from IDLE, so next_state is still live
      case (w_fsm_nxt)
        RD_NXT:     r_mem_addr <= next_state;
        RD_CUR, WR: r_mem_addr <= w_cur_addr;
        default:    r_mem_addr <= r_mem_addr;
      endcase

      // During RD_CUR the data returning is the s' row
      if (r_fsm == RD_CUR && !r_terminal)
        r_max_next <= w_row_max;

      // During CAP the data returning is the s row
      if (r_fsm == CAP) begin
        r_row  <= mem_rdata;
        r_q_sa <= mem_rdata[w_lane +: Q_W];
      end

      if (r_fsm == CALC) begin
        r_q_new     <= w_q_new;
        r_mem_wdata <= w_wdata;
      end
    end
  end

  assign busy      = r_busy;
  assign upd_done  = r_upd_done;
  assign q_new     = r_q_new;
  assign mem_addr  = r_mem_addr;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_wr_en = r_mem_wr_en;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_q_updater.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_updater
// Description : Directed self-checking bench for q_updater with a behavioural
//               synchronous Q-table memory and a write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_updater;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  state;
  logic [3:0]  action;
  logic [3:0]  next_state;
  logic [15:0] reward;
  logic        terminal;
  logic        busy;
  logic        upd_done;
  logic [15:0] q_new;
  logic [3:0]  mem_addr;
  logic        mem_rd_en;
  logic [63:0] mem_rdata;
  logic        mem_wr_en;
  logic [63:0] mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [63:0] row;
    logic [15:0] q;
  } sb_t;
  sb_t sb_q[$];

  logic [63:0] mem [16];

  always #5 clk = ~clk;

  q_updater #(.STATE_W(4), .ALPHA_SHIFT(2), .GAMMA_SHIFT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .state      (state),
    .action     (action),
    .next_state (next_state),
    .reward     (reward),
    .terminal   (terminal),
    .busy       (busy),
    .upd_done   (upd_done),
    .q_new      (q_new),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata)
  );

  // Single-port synchronous Q-table, one cycle read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference TD update: alpha = 1/4, gamma = 7/8, floor rounding, clamp
  function automatic int model_q(input int q_sa, input int maxn, input int rew, input bit term);
    int disc, target, delta, d, upd;
    disc   = term ? 0 : maxn - (maxn / 8);
    target = rew + disc;
    delta  = target - q_sa;
    d      = (delta >= 0) ? delta / 4 : -((-delta + 3) / 4);
    upd    = q_sa + d;
    if (upd < 0)     upd = 0;
    if (upd > 65535) upd = 65535;
    return upd;
  endfunction

  task automatic do_update(input logic [3:0] st, input logic [3:0] nx, input logic [3:0] act,
                           input logic [15:0] rew, input bit term, input int lit_q,
                           input bit pulse_busy);
    logic [63:0] cur, nrow, exp_row;
    logic [3:0]  rd_addr [4];
    int lsb, q_sa, maxn, q, wr_cyc, rd_cnt;
    bit  overlap, extra_wr;
    sb_t e;

    cur  = mem[st];
    nrow = mem[nx];
    lsb  = (3 - int'(act[1:0])) * 16;
    q_sa = int'(cur[lsb +: 16]);
    maxn = 0;
    for (int i = 0; i < 4; i++)
      if (int'(nrow[i*16 +: 16]) > maxn) maxn = int'(nrow[i*16 +: 16]);
    q = model_q(q_sa, maxn, int'($signed(rew)), term);
    exp_row = cur;
    exp_row[lsb +: 16] = q[15:0];
    sb_q.push_back('{addr: st, row: exp_row, q: q[15:0]});

    @(negedge clk);
    state = st; next_state = nx; action = act; reward = rew; terminal = term; start = 1'b1;
    @(negedge clk);
    // Accepted at the previous edge; later input changes must be ignored
    start = 1'b0; state = ~st; next_state = ~nx; action = ~act; reward = ~rew; terminal = ~term;

    wr_cyc = 0; rd_cnt = 0; overlap = 0;
    for (int c = 1; c <= 10 && wr_cyc == 0; c++) begin
      if (c == 1) check("busy_c1", 64'(busy), 64'd1);
      if (mem_rd_en && mem_wr_en) overlap = 1;
      if (mem_rd_en) begin
        if (rd_cnt < 4) rd_addr[rd_cnt] = mem_addr;
        rd_cnt++;
      end
      if (mem_wr_en) begin
        wr_cyc = c;
        if (sb_q.size() == 0) begin
          check("sb_unexpected_wr", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr",  64'(mem_addr), 64'(e.addr));
          check("wr_data",  mem_wdata, e.row);
          check("upd_done", 64'(upd_done), 64'd1);
          check("busy_wr",  64'(busy), 64'd1);
        end
      end
      if (pulse_busy && c == 2) begin
        start = 1'b1; state = st + 4'd1; next_state = st + 4'd1; terminal = 1'b1;
      end
      if (pulse_busy && c == 3) start = 1'b0;
      @(negedge clk);
    end

    check("wr_cycle", 64'(wr_cyc), term ? 64'd4 : 64'd5);
    check("rd_rw_overlap", 64'(overlap), 64'd0);
    check("rd_count", 64'(rd_cnt), term ? 64'd1 : 64'd2);
    if (rd_cnt >= 1) check("rd_addr0", 64'(rd_addr[0]), term ? 64'(st) : 64'(nx));
    if (!term && rd_cnt >= 2) check("rd_addr1", 64'(rd_addr[1]), 64'(st));
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(upd_done), 64'd0);
    check("q_new", 64'(q_new), 64'(q));
    if (lit_q >= 0) check("q_new_plan", 64'(q_new), 64'(lit_q));

    if (pulse_busy) begin
      extra_wr = 0;
      for (int c = 0; c < 8; c++) begin
        if (mem_wr_en || busy) extra_wr = 1;
        @(negedge clk);
      end
      check("dropped_start", 64'(extra_wr), 64'd0);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] saved;
    bit bad;

    for (int i = 0; i < 16; i++) mem[i] = 64'(i) * 64'h0001_0002_0003_0004;
    mem[1] = {16'd11, 16'd22, 16'd100, 16'd33};
    mem[2] = {16'd5, 16'd800, 16'd799, 16'd0};
    mem[3] = {16'd7, 16'd400, 16'd9, 16'd8};
    mem[4] = {16'd10, 16'd1, 16'd2, 16'd3};
    mem[5] = {16'd1, 16'd2, 16'd3, 16'd65000};
    mem[6] = {16'hFFFF, 16'd0, 16'd0, 16'd0};
    mem[7] = {16'd1000, 16'd2000, 16'd3000, 16'd4000};
    mem[8] = {16'd500, 16'd600, 16'd700, 16'd800};
    mem[10] = {16'd1234, 16'd4321, 16'd1111, 16'd2222};

    rst = 1'b1; start = 1'b0; state = '0; action = '0; next_state = '0;
    reward = '0; terminal = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_done",  64'(upd_done), 64'd0);
    check("rst_q_new", 64'(q_new), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_addr",  64'(mem_addr), 64'd0);
    check("rst_wdata", mem_wdata, 64'd0);
    rst = 1'b0;

    // Non-terminal, action 2
    do_update(4'd1, 4'd2, 4'd2, 16'd50, 1'b0, 262, 1'b0);
    // Terminal, action 1
    do_update(4'd3, 4'd2, 4'd1, -16'sd200, 1'b1, 250, 1'b0);
    // Low saturation, action 0 (top lane)
    do_update(4'd4, 4'd9, 4'd0, 16'h8000, 1'b1, 0, 1'b0);
    // High saturation, action 7 aliases to lane [15:0]
    do_update(4'd5, 4'd6, 4'd7, 16'd32767, 1'b0, 65535, 1'b0);
    // Same row for s and s'
    do_update(4'd7, 4'd7, 4'd1, 16'd0, 1'b0, 2375, 1'b0);
    // Start pulsed while busy is dropped
    do_update(4'd8, 4'd3, 4'd2, 16'd20, 1'b0, -1, 1'b1);

    // Reset during CALC: no write, outputs cleared at once
    saved = mem[10];
    @(negedge clk);
    state = 4'd10; next_state = 4'd11; action = 4'd1; reward = 16'd100; terminal = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("calc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("rstc_busy",  64'(busy), 64'd0);
    check("rstc_done",  64'(upd_done), 64'd0);
    check("rstc_q_new", 64'(q_new), 64'd0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr_en || busy || upd_done) bad = 1;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr_en || busy) bad = 1;
    end
    check("rstc_no_write", 64'(bad), 64'd0);
    check("rstc_row_kept", mem[10], saved);

    // Normal update after the aborted one
    do_update(4'd10, 4'd1, 4'd3, 16'd100, 1'b0, -1, 1'b0);
    check("sb_final_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
